// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcode/funct
// constants, datapath select codes and the per-state Moore control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR};
    endfunction

    // Moore part of the control word; Mealy strobes are added in the top.
    function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c           = '0;
        c.pc_source = PCSRC_ALU;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_ADD;
        case (s)
            S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRCB_ONE; end
            S_DECODE: c.alu_src_b = SRCB_BOFF;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
            S_MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                if (op == OP_RTYPE) c.alu_op = ALUOP_FUNCT;
                else                c.alu_src_b = SRCB_IMM;
            end
            S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
            S_IWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.done          = 1'b1;
            end
            S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; c.done = 1'b1; end
            S_JR:     begin c.pc_write = 1'b1; c.pc_source = PCSRC_RS; c.done = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state and flags a timeout
// once MAX_WAIT such cycles have elapsed and memory is still not ready.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    logic [WAIT_W-1:0] r_count;

    // Every exit from a wait state happens on ready, so clearing here also
    // clears the count on entry to the next wait state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       r_count <= '0;
        else if (!i_active || i_ready)   r_count <= '0;
        else                             r_count <= r_count + WAIT_W'(1);
    end

    assign o_timeout = i_active && !i_ready && (r_count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable and mux select.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [3:0] state_out
);

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   r_mem_fault;
    logic   w_wait_state;
    logic   w_timeout;
    logic   w_illegal;
    logic   w_unused;

    // zero is combined with pc_write_cond in the datapath, not here.
    assign w_unused = zero;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .i_active  (w_wait_state),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: w_illegal = 1'b0;
            OP_RTYPE: w_illegal = !funct_legal(funct);
            default:  w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_FAULT;
            S_DECODE: begin
                if (w_illegal) w_next = S_FETCH;
                else begin
                    case (opcode)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = (funct == FN_JR) ? S_JR : S_EXEC;
                        OP_ADDI:      w_next = S_EXEC;
                        OP_BEQ:       w_next = S_BRANCH;
                        OP_J:         w_next = S_JUMP;
                        default:      w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB; else if (w_timeout) w_next = S_FAULT;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH; else if (w_timeout) w_next = S_FAULT;
            S_EXEC:   w_next = (opcode == OP_RTYPE) ? S_RWB : S_IWB;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Control word is registered from the next state so it is aligned with r_state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ctrl      <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next, opcode);
            if (w_next == S_FAULT) r_mem_fault <= 1'b1;
        end
    end

    assign ir_write      = (r_state == S_FETCH) && mem_ready;
    assign pc_write      = r_ctrl.pc_write || ir_write;
    assign instr_done    = r_ctrl.done || ((r_state == S_MEMWR) && mem_ready);
    assign illegal_op    = (r_state == S_DECODE) && w_illegal;
    assign pc_write_cond = r_ctrl.pc_write_cond;
    assign pc_source     = r_ctrl.pc_source;
    assign i_or_d        = r_ctrl.i_or_d;
    assign mem_read      = r_ctrl.mem_read;
    assign mem_write     = r_ctrl.mem_write;
    assign reg_write     = r_ctrl.reg_write;
    assign reg_dst       = r_ctrl.reg_dst;
    assign mem_to_reg    = r_ctrl.mem_to_reg;
    assign alu_src_a     = r_ctrl.alu_src_a;
    assign alu_src_b     = r_ctrl.alu_src_b;
    assign alu_op        = r_ctrl.alu_op;
    assign mem_fault     = r_mem_fault;
    assign state_out     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a phase-list reference model; every
// cycle's full output vector is compared with the expected one.
module tb_multicycle_control;

    localparam int MW = 4;

    logic       clock, reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op, mem_fault;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_out;
    logic [22:0] w_got;

    int n_cmp = 0;
    int n_err = 0;

    int q_st[$];
    int q_rdy[$];
    bit q_flt;

    multicycle_control #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_fault(mem_fault), .state_out(state_out)
    );

    assign w_got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    instr_done, illegal_op, mem_fault, state_out};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
        return op inside {6'h23, 6'h2B, 6'h08, 6'h04, 6'h02};
    endfunction

    // Expected outputs straight from the per-phase control table.
    function automatic logic [22:0] exp_vec(input int s, input logic [5:0] op, input bit rdy, input bit ill);
        logic pcw, pcc, iord, rd, wr, irw, rw, rdst, m2r, srca, done, il, flt;
        logic [1:0] pcs, srcb, aop;
        {pcw, pcc, iord, rd, wr, irw, rw, rdst, m2r, srca, done, il, flt} = '0;
        {pcs, srcb, aop} = '0;
        case (s)
            1:  begin rd = 1; srcb = 2'b01; pcw = rdy; irw = rdy; end
            2:  begin srcb = 2'b11; il = ill; end
            3:  begin srca = 1; srcb = 2'b10; end
            4:  begin rd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; done = 1; end
            6:  begin wr = 1; iord = 1; done = rdy; end
            7:  begin srca = 1; if (op == 6'h00) aop = 2'b10; else srcb = 2'b10; end
            8:  begin rw = 1; rdst = 1; done = 1; end
            9:  begin rw = 1; done = 1; end
            10: begin srca = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; done = 1; end
            11: begin pcw = 1; pcs = 2'b10; done = 1; end
            12: begin pcw = 1; pcs = 2'b11; done = 1; end
            15: flt = 1;
            default: ;
        endcase
        return {pcw, pcc, pcs, iord, rd, wr, irw, rw, rdst, m2r, srca, srcb, aop, done, il, flt, 4'(s)};
    endfunction

    task automatic push_plain(input int st);
        q_st.push_back(st);
        q_rdy.push_back(int'($urandom_range(0, 1)));
    endtask

    // A memory phase lasting w not-ready cycles; beyond MW it ends in FAULT.
    task automatic push_wait(input int st, input int w);
        int lim = (w > MW) ? MW : w;
        for (int i = 0; i <= lim; i++) begin
            q_st.push_back(st);
            q_rdy.push_back((i == w) ? 1 : 0);
        end
        if (w > MW) begin
            q_flt = 1'b1;
            repeat (3) push_plain(15);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm,
                             input bit abort_wr, output bit faulted);
        bit ill;
        q_st.delete(); q_rdy.delete(); q_flt = 1'b0;
        ill = !legal(op, fn);
        push_wait(1, wf);
        if (!q_flt) begin
            push_plain(2);
            if (!ill) begin
                if (op == 6'h23 || op == 6'h2B) begin
                    push_plain(3);
                    push_wait((op == 6'h23) ? 4 : 6, wm);
                    if (!q_flt && op == 6'h23) push_plain(5);
                end else if (op == 6'h00 && fn == 6'h08) push_plain(12);
                else if (op == 6'h00) begin push_plain(7); push_plain(8); end
                else if (op == 6'h08) begin push_plain(7); push_plain(9); end
                else if (op == 6'h04) push_plain(10);
                else push_plain(11);
            end
        end
        faulted = q_flt;
        opcode = op;
        funct  = fn;
        for (int k = 0; k < q_st.size(); k++) begin
            mem_ready = q_rdy[k][0];
            zero      = 1'($urandom);
            @(negedge clock);
            chk("cycle", 32'(w_got), 32'(exp_vec(q_st[k], op, q_rdy[k][0], ill)));
            if (abort_wr && q_st[k] == 6) begin
                reset = 1'b1;
                #1;
                chk("rst_mid_wr", 32'(w_got), 32'd0);
                return;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        #3;
        chk("rst_async", 32'(w_got), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("idle", 32'(w_got), 32'd0);
        @(posedge clock);
        #1;
    endtask

    function automatic int rnd_wait();
        if ($urandom_range(0, 11) == 0) return MW + 1 + int'($urandom_range(0, 2));
        return int'($urandom_range(0, MW));
    endfunction

    initial begin
        bit f;
        logic [5:0] fns [6];
        logic [5:0] op, fn;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        do_reset();

        run_instr(6'h00, 6'h20, 0, 0, 1'b0, f);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, f);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, f);
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, f);
        run_instr(6'h00, 6'h3F, 1, 0, 1'b0, f);
        run_instr(6'h2B, 6'h00, MW, MW, 1'b0, f);
        run_instr(6'h00, 6'h20, MW + 1, 0, 1'b0, f);
        if (f) do_reset();
        run_instr(6'h2B, 6'h00, 0, 3, 1'b1, f);
        do_reset();

        repeat (150) begin
            case ($urandom_range(0, 7))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h08;
                4: op = 6'h04;
                5: op = 6'h02;
                6: op = 6'h3F;
                default: op = 6'($urandom);
            endcase
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, fn, rnd_wait(), rnd_wait(), 1'b0, f);
            if (f) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
